// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time of three PWM phases over a
// programmable frame and hands each frame's counts to a consumer through
// a valid/ready handshake, with a sticky overrun flag.
// Optional macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-tap majority
// filter after each synchronizer (adds 2 cycles of latency).
module pwm_capture #(
  parameter int D_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               pwmA_in,
  input  logic               pwmB_in,
  input  logic               pwmC_in,
  input  logic [D_WIDTH-1:0] period_top,
  input  logic               enable,
  output logic [D_WIDTH-1:0] dutyA_out,
  output logic [D_WIDTH-1:0] dutyB_out,
  output logic [D_WIDTH-1:0] dutyC_out,
  output logic               valid,
  input  logic               ready,
  output logic               overrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [D_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0] pwm_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] lvl;

  assign pwm_raw = {pwmC_in, pwmB_in, pwmA_in};

  // Two-flop synchronizer on each asynchronous phase input
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pwm_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [2:0] tap1_q;
  logic [2:0] tap2_q;
  logic [2:0] filt_q;

  // Registered majority vote over the last three synchronized samples
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      tap1_q <= '0;
      tap2_q <= '0;
      filt_q <= '0;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      filt_q <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  state_t             state_q;
  logic [D_WIDTH-1:0] frame_cnt_q;
  logic [D_WIDTH-1:0] frame_top_q;
  logic [D_WIDTH-1:0] cnt_q  [3];
  logic [D_WIDTH-1:0] cnt_d  [3];
  logic [D_WIDTH-1:0] duty_q [3];
  logic               valid_q;
  logic               overrun_q;
  logic               frame_end;
  logic               load;

  // Per-phase count including this cycle's sample, saturating at all-ones
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_phase
      assign cnt_d[gi] = (lvl[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + 1'b1 : cnt_q[gi];
    end
  endgenerate

  assign frame_end = (frame_cnt_q == frame_top_q);
  assign load      = (state_q == MEASURE) && enable && frame_end;

  // Capture FSM: frame sequencing, accumulation, result hand-off and overrun
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      frame_top_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          frame_cnt_q <= '0;
          for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
          if (enable) begin
            frame_top_q <= period_top;
            state_q     <= MEASURE;
          end
        end
        MEASURE: begin
          if (!enable) begin
            // Partial frame is dropped; held results stay for the consumer
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
          end else if (frame_end) begin
            frame_cnt_q <= '0;
            frame_top_q <= period_top;
            for (int i = 0; i < 3; i++) begin
              duty_q[i] <= cnt_d[i];
              cnt_q[i]  <= '0;
            end
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
          end
        end
        default: state_q <= IDLE;
      endcase

      // A fresh load wins over a same-edge accept
      if (load) begin
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      if (!enable) begin
        overrun_q <= 1'b0;
      end else if (load && valid_q && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign dutyA_out = duty_q[0];
  assign dutyB_out = duty_q[1];
  assign dutyC_out = duty_q[2];
  assign valid     = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter D_WIDTH, default 19: width of period and duty-count buses.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rstb  input  1  reset, asynchronous, active-high.
REQ-004 pwmA_in, pwmB_in, pwmC_in  input  1 each  asynchronous phase PWM levels from the controller output.
REQ-005 period_top  input  D_WIDTH  frame length minus one, in clk cycles (unsigned).
REQ-006 enable  input  1  capture run/stop.
REQ-007 dutyA_out, dutyB_out, dutyC_out  output  D_WIDTH each  high-time counts of the last completed frame (unsigned).
REQ-008 valid  output  1  duty outputs hold a result not yet accepted.
REQ-009 ready  input  1  consumer accepts the result when valid and ready are both high on a clk edge.
REQ-010 overrun  output  1  sticky flag: an unaccepted result was overwritten.

Function
REQ-011 Each pwm input SHALL pass through a 2-flop synchronizer; all counting uses the synchronized level.
REQ-012 FSM states: IDLE and MEASURE.
REQ-013 IDLE: frame counter and phase counters held at 0; enable=1 moves to MEASURE on the next edge.
REQ-014 On entry to MEASURE and at every frame start, period_top SHALL be latched into frame_top; changes mid-frame take effect next frame.
REQ-015 MEASURE: frame counter increments each cycle from 0 to frame_top, then wraps to 0.
REQ-016 Each phase counter increments in every frame cycle in which its synchronized input is 1, and saturates at 2^D_WIDTH-1.
REQ-017 On the cycle frame counter equals frame_top, the final counts including that cycle's sample SHALL be loaded into dutyX_out, valid set to 1 on the next edge, and phase counters cleared.
REQ-018 frame_top=0 SHALL give 1-cycle frames; each duty is 0 or 1.
REQ-019 valid clears on the edge where valid and ready are both 1, unless a new result loads on that same edge, in which case valid stays 1 and overrun is not set.
REQ-020 If a new result loads while valid=1 and ready=0, outputs are overwritten, valid stays 1, and overrun is set to 1.
REQ-021 overrun clears only on reset or on enable going 0.
REQ-022 enable=0 in MEASURE: the partial frame is discarded, the FSM returns to IDLE next edge, and dutyX_out/valid keep their values until accepted.
REQ-023 Input-to-count latency SHALL be 2 cycles (3-tap filter adds 2: 4 cycles).

Reset
REQ-024 rstb=1 SHALL immediately force the FSM to IDLE, all counters, dutyA/B/C_out, valid and overrun to 0, and synchronizer/filter flops to 0.
REQ-025 Reset asserted mid-frame discards the frame; after release, capture restarts only via REQ-013.

Configuration
REQ-026 Macro PWM_CAPTURE_GLITCH_FILTER_EN: when defined, each synchronized input passes through a 3-tap majority filter, adding 2 cycles of latency; when undefined, there is no filter and latency is 2 cycles.

Verification
REQ-027 period_top=99, enable=1, pwmA 25% / pwmB 50% / pwmC 0% aligned to the frame, ready=1 -> each frame gives dutyA=25, dutyB=50, dutyC=0, valid high 1 cycle per 100.
REQ-028 period_top=9, all inputs constant 1, ready=0 for 3 frames -> duties=10, valid held high, overrun=1 after the 2nd frame, then ready=1 -> valid clears in 1 cycle.
REQ-029 period_top changed 99->49 mid-frame -> current frame still 100 cycles, next frame 50 cycles, duties scale accordingly.
REQ-030 enable dropped at frame cycle 40 -> no new result, FSM in IDLE, prior valid result preserved, overrun=0.
REQ-031 rstb pulsed mid-frame with valid=1 -> all outputs 0 at once, no result until enable re-asserted.
REQ-032 With PWM_CAPTURE_GLITCH_FILTER_EN, 1-cycle high glitches on pwmA at constant 0 -> dutyA=0; without the macro, dutyA equals the glitch count.
